// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one fixed-latency memory port between the fetch
// stage and the memory stage. Data wins arbitration (older instruction)
// unless fetch has lost STARVE_MAX consecutive times. Transactions are
// serialised through IDLE -> ISSUE -> WAIT -> RESP, and read data is returned
// in a registered RDATA with a one-cycle VALID pulse.
module otter_mem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_VALID,
    output logic        IF_STALL,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    output logic [31:0] D_RDATA,
    output logic        D_VALID,
    output logic        D_STALL,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [1:0]  MEM_SIZE,
    input  logic [31:0] MEM_RDATA,
    output logic        BUSY
);

    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t            state_r,     state_s;
    owner_t            owner_r,     owner_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic [STV_W-1:0]  starve_r,    starve_s;
    logic              mem_en_r,    mem_en_s;
    logic              mem_we_r,    mem_we_s;
    logic [31:0]       mem_addr_r,  mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic [1:0]        mem_size_r,  mem_size_s;
    logic [31:0]       if_rdata_r,  if_rdata_s;
    logic [31:0]       d_rdata_r,   d_rdata_s;
    logic              if_valid_r,  if_valid_s;
    logic              d_valid_r,   d_valid_s;
    logic              busy_r,      busy_s;
    logic              fetch_win_s;

    // Next-state, arbitration and next-value logic for every register.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        starve_s    = starve_r;
        mem_en_s    = 1'b0;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_size_s  = mem_size_r;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        if_valid_s  = 1'b0;
        d_valid_s   = 1'b0;
        // Fetch only beats a pending data request once it has been starved.
        fetch_win_s = IF_REQ && (!D_REQ || (starve_r == STV_MAX));

        case (state_r)
            ST_IDLE: begin
                if (IF_REQ || D_REQ) begin
                    state_s  = ST_ISSUE;
                    mem_en_s = 1'b1;
                    if (fetch_win_s) begin
                        owner_s    = OWN_IF;
                        mem_addr_s = IF_ADDR;
                        mem_we_s   = 1'b0;
                        mem_size_s = 2'b10;
                        starve_s   = {STV_W{1'b0}};
                    end else begin
                        owner_s     = OWN_D;
                        mem_addr_s  = D_ADDR;
                        mem_wdata_s = D_WDATA;
                        mem_we_s    = D_WE;
                        mem_size_s  = D_SIZE;
                        if (IF_REQ && (starve_r != STV_MAX)) begin
                            starve_s = starve_r + STV_W'(1);
                        end else begin
                            starve_s = starve_r;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s   = CNT_LOAD;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_RESP;
                    if (owner_r == OWN_IF) begin
                        if_rdata_s = MEM_RDATA;
                        if_valid_s = 1'b1;
                    end else begin
                        d_valid_s = 1'b1;
                        // Stores leave the previous load data in place.
                        if (!mem_we_r) begin
                            d_rdata_s = MEM_RDATA;
                        end else begin
                            d_rdata_s = d_rdata_r;
                        end
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Requester still shows REQ here; do not re-grant it.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_IF;
            cnt_r       <= {CNT_W{1'b0}};
            starve_r    <= {STV_W{1'b0}};
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_size_r  <= 2'b00;
            if_rdata_r  <= 32'h0000_0000;
            d_rdata_r   <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            d_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            starve_r    <= starve_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_size_r  <= mem_size_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            if_valid_r  <= if_valid_s;
            d_valid_r   <= d_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign IF_RDATA  = if_rdata_r;
    assign IF_VALID  = if_valid_r;
    assign IF_STALL  = IF_REQ & ~if_valid_r;
    assign D_RDATA   = d_rdata_r;
    assign D_VALID   = d_valid_r;
    assign D_STALL   = D_REQ & ~d_valid_r;
    assign MEM_EN    = mem_en_r;
    assign MEM_WE    = mem_we_r;
    assign MEM_ADDR  = mem_addr_r;
    assign MEM_WDATA = mem_wdata_r;
    assign MEM_SIZE  = mem_size_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: two builds (LATENCY=2/STARVE_MAX=4 and
// LATENCY=1/STARVE_MAX=2) checked every cycle against a transaction-timeline
// model, plus directed scenarios with hand-computed expectations.
module tb_otter_mem_arbiter;

    logic clk;
    logic rst;
    logic [1:0]       if_req, d_req, d_we;
    logic [1:0][31:0] if_addr, d_addr, d_wdata, mrd;
    logic [1:0][1:0]  d_size;
    logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]       if_valid, if_stall, d_valid, d_stall, mem_en, mem_we, busy;
    logic [1:0][1:0]  mem_size;

    otter_mem_arbiter #(.LATENCY(2), .STARVE_MAX(4)) u_dut0 (
        .CLK(clk), .RST(rst),
        .IF_REQ(if_req[0]), .IF_ADDR(if_addr[0]), .IF_RDATA(if_rdata[0]),
        .IF_VALID(if_valid[0]), .IF_STALL(if_stall[0]),
        .D_REQ(d_req[0]), .D_WE(d_we[0]), .D_ADDR(d_addr[0]), .D_WDATA(d_wdata[0]),
        .D_SIZE(d_size[0]), .D_RDATA(d_rdata[0]), .D_VALID(d_valid[0]), .D_STALL(d_stall[0]),
        .MEM_EN(mem_en[0]), .MEM_WE(mem_we[0]), .MEM_ADDR(mem_addr[0]),
        .MEM_WDATA(mem_wdata[0]), .MEM_SIZE(mem_size[0]), .MEM_RDATA(mrd[0]), .BUSY(busy[0])
    );

    otter_mem_arbiter #(.LATENCY(1), .STARVE_MAX(2)) u_dut1 (
        .CLK(clk), .RST(rst),
        .IF_REQ(if_req[1]), .IF_ADDR(if_addr[1]), .IF_RDATA(if_rdata[1]),
        .IF_VALID(if_valid[1]), .IF_STALL(if_stall[1]),
        .D_REQ(d_req[1]), .D_WE(d_we[1]), .D_ADDR(d_addr[1]), .D_WDATA(d_wdata[1]),
        .D_SIZE(d_size[1]), .D_RDATA(d_rdata[1]), .D_VALID(d_valid[1]), .D_STALL(d_stall[1]),
        .MEM_EN(mem_en[1]), .MEM_WE(mem_we[1]), .MEM_ADDR(mem_addr[1]),
        .MEM_WDATA(mem_wdata[1]), .MEM_SIZE(mem_size[1]), .MEM_RDATA(mrd[1]), .BUSY(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per build, cycles elapsed since the grant decision (0 = idle).
    int          lat_m  [2] = '{2, 1};
    int          smax_m [2] = '{4, 2};
    int          ph     [2];
    int          starve_m [2];
    bit          own_d  [2];
    bit          we_m   [2];
    logic [31:0] addr_m [2], wd_m [2], ird_m [2], drd_m [2];
    logic [1:0]  sz_m   [2];
    bit          done_i [2], done_d [2];

    int          en_q [$], dv_q [$], iv_q [$];
    logic [31:0] addr_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int qat(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] aat(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic bit vexp(input int k);
        return ph[k] == 2 + lat_m[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; starve_m[k] = 0; own_d[k] = 1'b0; we_m[k] = 1'b0;
            addr_m[k] = 32'h0; wd_m[k] = 32'h0; sz_m[k] = 2'b00;
            ird_m[k] = 32'h0; drd_m[k] = 32'h0;
        end
    endtask

    // Advance the model over the coming clock edge using this cycle's inputs.
    task automatic model_next();
        for (int k = 0; k < 2; k++) begin
            int lat = lat_m[k];
            if (rst) begin
                if (ph[k] == 0) begin
                    if (if_req[k] || d_req[k]) begin
                        if (if_req[k] && (!d_req[k] || starve_m[k] == smax_m[k])) begin
                            own_d[k] = 1'b0; addr_m[k] = if_addr[k]; we_m[k] = 1'b0;
                            sz_m[k] = 2'b10; starve_m[k] = 0;
                        end else begin
                            own_d[k] = 1'b1; addr_m[k] = d_addr[k]; wd_m[k] = d_wdata[k];
                            we_m[k] = d_we[k]; sz_m[k] = d_size[k];
                            if (if_req[k] && starve_m[k] < smax_m[k]) starve_m[k]++;
                        end
                        ph[k] = 1;
                    end
                end else if (ph[k] == 1 + lat) begin
                    if (!own_d[k]) ird_m[k] = mrd[k];
                    else if (!we_m[k]) drd_m[k] = mrd[k];
                    ph[k]++;
                end else if (ph[k] == 2 + lat) begin
                    ph[k] = 0;
                end else begin
                    ph[k]++;
                end
            end
        end
    endtask

    task automatic check_stall();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("if_stall[%0d]", k), 32'(if_stall[k]), 32'(if_req[k] && !(vexp(k) && !own_d[k])));
            chk($sformatf("d_stall[%0d]", k), 32'(d_stall[k]), 32'(d_req[k] && !(vexp(k) && own_d[k])));
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mem_en[%0d]", k),    32'(mem_en[k]),   32'(ph[k] == 1));
            chk($sformatf("busy[%0d]", k),      32'(busy[k]),     32'(ph[k] != 0));
            chk($sformatf("if_valid[%0d]", k),  32'(if_valid[k]), 32'(vexp(k) && !own_d[k]));
            chk($sformatf("d_valid[%0d]", k),   32'(d_valid[k]),  32'(vexp(k) && own_d[k]));
            chk($sformatf("if_rdata[%0d]", k),  if_rdata[k],      ird_m[k]);
            chk($sformatf("d_rdata[%0d]", k),   d_rdata[k],       drd_m[k]);
            chk($sformatf("mem_addr[%0d]", k),  mem_addr[k],      addr_m[k]);
            chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k],     wd_m[k]);
            chk($sformatf("mem_size[%0d]", k),  32'(mem_size[k]), 32'(sz_m[k]));
            chk($sformatf("mem_we[%0d]", k),    32'(mem_we[k]),   32'(we_m[k]));
        end
    endtask

    // One clock: inputs for the current cycle are already applied.
    task automatic cycle();
        #1;
        check_stall();
        model_next();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    // Directed run on build k; reqs drop the cycle after VALID unless keep.
    task automatic run_dir(input int k, input int ncy, input bit keep);
        bit drop_i = 1'b0;
        bit drop_d = 1'b0;
        en_q.delete(); dv_q.delete(); iv_q.delete(); addr_q.delete();
        for (int c = 1; c <= ncy; c++) begin
            mrd[k] = 32'hA000_0000 + 32'(c - 1);
            cycle();
            if (mem_en[k]) begin en_q.push_back(c); addr_q.push_back(mem_addr[k]); end
            if (d_valid[k]) dv_q.push_back(c);
            if (if_valid[k]) iv_q.push_back(c);
            if (!keep) begin
                if (drop_d) d_req[k] = 1'b0;
                if (drop_i) if_req[k] = 1'b0;
                drop_d = d_valid[k];
                drop_i = if_valid[k];
            end
        end
    endtask

    task automatic drive_random(input int k);
        if (done_i[k]) begin
            if_req[k] = 1'($urandom_range(0, 1)); if_addr[k] = $urandom; done_i[k] = 1'b0;
        end else if (!if_req[k]) begin
            if_req[k] = ($urandom_range(0, 2) == 0); if_addr[k] = $urandom;
        end else if (ph[k] >= 2 && !own_d[k] && $urandom_range(0, 15) == 0) begin
            if_req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            if_addr[k] = $urandom;
        end
        if (done_d[k] || !d_req[k]) begin
            d_req[k] = ($urandom_range(0, 1) == 0); done_d[k] = 1'b0;
            d_we[k] = 1'($urandom_range(0, 1)); d_addr[k] = $urandom;
            d_wdata[k] = $urandom; d_size[k] = 2'($urandom_range(0, 3));
        end else if (ph[k] >= 2 && own_d[k] && $urandom_range(0, 15) == 0) begin
            d_req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            d_addr[k] = $urandom; d_wdata[k] = $urandom; d_we[k] = 1'($urandom_range(0, 1));
        end
        if (vexp(k) && !own_d[k]) done_i[k] = 1'b1;
        if (vexp(k) && own_d[k]) done_d[k] = 1'b1;
        mrd[k] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0; mrd = '0;
        for (int k = 0; k < 2; k++) begin done_i[k] = 1'b0; done_d[k] = 1'b0; end
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_en", 32'(mem_en[0]), 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_mem_addr", mem_addr[0], 32'h0);
        chk("rst_if_rdata", if_rdata[0], 32'h0);
        check_regs();
        rst = 1'b1;
        cycle();

        // Single fetch on LATENCY=2.
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0100; mrd[0] = 32'h0;
        #1 chk("a_stall_c0", 32'(if_stall[0]), 32'h1);
        cycle();
        chk("a_en_c1", 32'(mem_en[0]), 32'h1);
        chk("a_addr_c1", mem_addr[0], 32'h0000_0100);
        chk("a_we_c1", 32'(mem_we[0]), 32'h0);
        cycle();
        cycle();
        mrd[0] = 32'hDEAD_BEEF;
        #1 chk("a_stall_c3", 32'(if_stall[0]), 32'h1);
        cycle();
        chk("a_valid_c4", 32'(if_valid[0]), 32'h1);
        chk("a_rdata_c4", if_rdata[0], 32'hDEAD_BEEF);
        #1 chk("a_stall_c4", 32'(if_stall[0]), 32'h0);
        mrd[0] = 32'h0;
        cycle();
        chk("a_valid_c5", 32'(if_valid[0]), 32'h0);
        if_req[0] = 1'b0;
        cycle(); cycle();

        // Simultaneous fetch and load: data first, then fetch.
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0400;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_2000; d_size[0] = 2'b10;
        run_dir(0, 12, 1'b0);
        chk("b_n_en", 32'(en_q.size()), 32'd2);
        chk("b_en0", qat(en_q, 0), 32'd1);
        chk("b_en1", qat(en_q, 1), 32'd6);
        chk("b_addr0", aat(0), 32'h0000_2000);
        chk("b_addr1", aat(1), 32'h0000_0400);
        chk("b_dvalid", qat(dv_q, 0), 32'd4);
        chk("b_ivalid", qat(iv_q, 0), 32'd9);
        chk("b_d_rdata", d_rdata[0], 32'hA000_0003);
        chk("b_if_rdata", if_rdata[0], 32'hA000_0008);

        // Store: no capture into D_RDATA.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h0000_3004;
        d_wdata[0] = 32'h1234_5678; d_size[0] = 2'b00;
        run_dir(0, 6, 1'b0);
        chk("c_en", qat(en_q, 0), 32'd1);
        chk("c_dvalid", qat(dv_q, 0), 32'd4);
        chk("c_addr", mem_addr[0], 32'h0000_3004);
        chk("c_wdata", mem_wdata[0], 32'h1234_5678);
        chk("c_size", 32'(mem_size[0]), 32'h0);
        chk("c_we", 32'(mem_we[0]), 32'h1);
        chk("c_d_rdata", d_rdata[0], 32'hA000_0003);
        d_we[0] = 1'b0;

        // Starvation: four data grants, then fetch, then data again.
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0100;
        d_req[0] = 1'b1; d_addr[0] = 32'h0000_2000;
        run_dir(0, 30, 1'b1);
        chk("d_n_en", 32'(en_q.size()), 32'd6);
        for (int i = 0; i < 4; i++) chk($sformatf("d_addr%0d", i), aat(i), 32'h0000_2000);
        chk("d_addr4", aat(4), 32'h0000_0100);
        chk("d_addr5", aat(5), 32'h0000_2000);
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        // Reset in WAIT of a fetch.
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0500;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("e_mem_en", 32'(mem_en[0]), 32'h0);
        chk("e_busy", 32'(busy[0]), 32'h0);
        chk("e_mem_addr", mem_addr[0], 32'h0);
        chk("e_mem_size", 32'(mem_size[0]), 32'h0);
        chk("e_if_rdata", if_rdata[0], 32'h0);
        model_reset();
        if_req[0] = 1'b0;
        cycle();
        rst = 1'b1;
        run_dir(0, 6, 1'b0);
        chk("e_no_valid", 32'(iv_q.size()), 32'd0);
        chk("e_no_en", 32'(en_q.size()), 32'd0);
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0600;
        run_dir(0, 6, 1'b0);
        chk("e_en", qat(en_q, 0), 32'd1);
        chk("e_ivalid", qat(iv_q, 0), 32'd4);
        chk("e_rdata", if_rdata[0], 32'hA000_0003);

        // LATENCY=1 build: VALID in cycle 3, no double grant.
        if_req[1] = 1'b1; if_addr[1] = 32'h0000_0700;
        run_dir(1, 6, 1'b0);
        chk("f_n_en", 32'(en_q.size()), 32'd1);
        chk("f_en", qat(en_q, 0), 32'd1);
        chk("f_n_valid", 32'(iv_q.size()), 32'd1);
        chk("f_ivalid", qat(iv_q, 0), 32'd3);
        chk("f_rdata", if_rdata[1], 32'hA000_0002);

        // Randomised traffic on both builds with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (!rst) rst = 1'b1;
            for (int k = 0; k < 2; k++) drive_random(k);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_regs();
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
